// File: rtl/datapath_issue_if.sv
// Instruction handshake bus between the instruction FIFO (master) and the issue sequencer (slave).
interface datapath_issue_if #(
   parameter int unsigned RF_ADDRW = 9,
   parameter int unsigned ADDRW    = 9,
   parameter int unsigned LENW     = 8
) ();
   logic                inst_valid;
   logic                inst_ready;
   logic [RF_ADDRW-1:0] inst_rfaddr;
   logic [LENW-1:0]     inst_len;
   logic [ADDRW-1:0]    inst_aaddr;
   logic                inst_accum;
   logic                inst_last;
   logic                inst_reduce;

   modport master (
      output inst_valid, inst_rfaddr, inst_len, inst_aaddr, inst_accum, inst_last, inst_reduce,
      input  inst_ready
   );

   modport slave (
      input  inst_valid, inst_rfaddr, inst_len, inst_aaddr, inst_accum, inst_last, inst_reduce,
      output inst_ready
   );
endinterface

// File: rtl/datapath_issue.sv
// Expands MVM instructions into LEN+1 per-cycle datapath beats, credit-gating result-producing
// beats so the downstream result FIFO can never overflow.
module datapath_issue #(
   parameter int unsigned RF_ADDRW = 9,
   parameter int unsigned ADDRW    = 9,
   parameter int unsigned LENW     = 8,
   parameter int unsigned CREDITS  = 16
) (
   input  logic                clk,
   input  logic                rst,
   datapath_issue_if.slave     inst_if,
   input  logic                i_credit,
   output logic [RF_ADDRW-1:0] o_rf_raddr,
   output logic                o_valid,
   output logic [ADDRW-1:0]    o_accum_addr,
   output logic                o_accum,
   output logic                o_last,
   output logic                o_reduce,
   output logic                o_busy,
   output logic                o_credit_err
);
   localparam int unsigned     CREDW    = $clog2(CREDITS + 1);
   localparam logic [CREDW-1:0] CRED_MAX = CREDW'(CREDITS);

   typedef enum logic {S_IDLE, S_ISSUE} state_e;

   state_e              state_q, state_d;
   logic [LENW-1:0]     beat_q, beat_d;
   logic [LENW-1:0]     len_q, len_d;
   logic [RF_ADDRW-1:0] rfaddr_q, rfaddr_d;
   logic [ADDRW-1:0]    aaddr_q, aaddr_d;
   logic                accum_q, accum_d;
   logic                last_q, last_d;
   logic                reduce_q, reduce_d;
   logic [CREDW-1:0]    credits_q, credits_d;
   logic                err_q, err_d;
   logic                ready_q, ready_d;
   logic                busy_q, busy_d;
   logic                valid_q, valid_d;
   logic [RF_ADDRW-1:0] raddr_q, raddr_d;
   logic [ADDRW-1:0]    oaddr_q, oaddr_d;
   logic                oaccum_q, oaccum_d;
   logic                olast_q, olast_d;
   logic                oreduce_q, oreduce_d;

   logic fire_c;
   logic accept_c;
   logic load_c;

   // Instruction context and FSM state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         beat_q   <= '0;
         len_q    <= '0;
         rfaddr_q <= '0;
         aaddr_q  <= '0;
         accum_q  <= 1'b0;
         last_q   <= 1'b0;
         reduce_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         beat_q   <= beat_d;
         len_q    <= len_d;
         rfaddr_q <= rfaddr_d;
         aaddr_q  <= aaddr_d;
         accum_q  <= accum_d;
         last_q   <= last_d;
         reduce_q <= reduce_d;
      end
   end

   // Credit counter, sticky error and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         credits_q <= CRED_MAX;
         err_q     <= 1'b0;
         ready_q   <= 1'b0;
         busy_q    <= 1'b0;
         valid_q   <= 1'b0;
         raddr_q   <= '0;
         oaddr_q   <= '0;
         oaccum_q  <= 1'b0;
         olast_q   <= 1'b0;
         oreduce_q <= 1'b0;
      end else begin
         credits_q <= credits_d;
         err_q     <= err_d;
         ready_q   <= ready_d;
         busy_q    <= busy_d;
         valid_q   <= valid_d;
         raddr_q   <= raddr_d;
         oaddr_q   <= oaddr_d;
         oaccum_q  <= oaccum_d;
         olast_q   <= olast_d;
         oreduce_q <= oreduce_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      beat_d    = beat_q;
      len_d     = len_q;
      rfaddr_d  = rfaddr_q;
      aaddr_d   = aaddr_q;
      accum_d   = accum_q;
      last_d    = last_q;
      reduce_d  = reduce_q;
      credits_d = credits_q;
      err_d     = err_q;
      valid_d   = 1'b0;
      raddr_d   = raddr_q;
      oaddr_d   = oaddr_q;
      oaccum_d  = oaccum_q;
      olast_d   = olast_q;
      oreduce_d = oreduce_q;
      load_c    = 1'b0;

      // A result-producing beat needs a free slot downstream
      fire_c   = (state_q == S_ISSUE) && !(last_q && (credits_q == '0));
      accept_c = inst_if.inst_valid && ready_q;

      case (state_q)
         S_IDLE: begin
            if (accept_c) begin
               load_c  = 1'b1;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (fire_c) begin
               valid_d   = 1'b1;
               raddr_d   = rfaddr_q + RF_ADDRW'(beat_q);
               oaddr_d   = aaddr_q + ADDRW'(beat_q);
               oaccum_d  = accum_q;
               olast_d   = last_q;
               oreduce_d = reduce_q;
               beat_d    = beat_q + LENW'(1);
               if (beat_q == len_q) begin
                  if (accept_c) load_c  = 1'b1;
                  else          state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (load_c) begin
         beat_d   = '0;
         len_d    = inst_if.inst_len;
         rfaddr_d = inst_if.inst_rfaddr;
         aaddr_d  = inst_if.inst_aaddr;
         accum_d  = inst_if.inst_accum;
         last_d   = inst_if.inst_last;
         reduce_d = inst_if.inst_reduce;
      end

      // A return at full count is dropped and flagged; consume and return cancel otherwise
      case ({i_credit, fire_c && last_q})
         2'b10: begin
            if (credits_q == CRED_MAX) err_d = 1'b1;
            else                       credits_d = credits_q + CREDW'(1);
         end
         2'b01: credits_d = credits_q - CREDW'(1);
         2'b11: begin
            if (credits_q == CRED_MAX) begin
               err_d     = 1'b1;
               credits_d = credits_q - CREDW'(1);
            end
         end
         default: credits_d = credits_q;
      endcase

      // Ready next cycle: idle, or the final beat will be able to fire
      ready_d = (state_d == S_IDLE) ||
                ((beat_d == len_d) && !(last_d && (credits_d == '0)));
      busy_d  = (state_d != S_IDLE);
   end

   assign inst_if.inst_ready = ready_q;
   assign o_rf_raddr         = raddr_q;
   assign o_valid            = valid_q;
   assign o_accum_addr       = oaddr_q;
   assign o_accum            = oaccum_q;
   assign o_last             = olast_q;
   assign o_reduce           = oreduce_q;
   assign o_busy             = busy_q;
   assign o_credit_err       = err_q;
endmodule

// File: tb/tb_datapath_issue.sv
// Bench for datapath_issue: queue-of-beats reference model checked every cycle, plus
// directed scenarios with hand-computed beat lists and timing.
module tb_datapath_issue;
   localparam int unsigned CRED = 16;

   logic       clk;
   logic       rst;
   logic       i_credit;
   logic [8:0] o_rf_raddr;
   logic       o_valid;
   logic [8:0] o_accum_addr;
   logic       o_accum;
   logic       o_last;
   logic       o_reduce;
   logic       o_busy;
   logic       o_credit_err;

   datapath_issue_if #(.RF_ADDRW(9), .ADDRW(9), .LENW(8)) ifc ();

   datapath_issue #(.RF_ADDRW(9), .ADDRW(9), .LENW(8), .CREDITS(CRED)) dut (
      .clk          (clk),
      .rst          (rst),
      .inst_if      (ifc),
      .i_credit     (i_credit),
      .o_rf_raddr   (o_rf_raddr),
      .o_valid      (o_valid),
      .o_accum_addr (o_accum_addr),
      .o_accum      (o_accum),
      .o_last       (o_last),
      .o_reduce     (o_reduce),
      .o_busy       (o_busy),
      .o_credit_err (o_credit_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic timeout(input string name);
      n_chk++;
      n_err++;
      $display("FAIL %s timed out t=%0t", name, $time);
   endtask

   // Reference model: every accepted instruction becomes a list of pending beats
   typedef struct {
      logic [8:0] ra;
      logic [8:0] aa;
      logic       acc;
      logic       lst;
      logic       red;
   } beat_t;

   beat_t      mq[$];
   int         m_credits;
   logic       m_err;
   logic       e_valid, e_acc, e_lst, e_red, e_ready, e_busy;
   logic [8:0] e_ra, e_aa;

   initial begin
      beat_t b;
      logic  acc, fire;
      int    pre;
      forever begin
         @(posedge clk or negedge rst);
         if (!rst) begin
            mq.delete();
            m_credits = CRED;
            m_err = 1'b0;
            {e_valid, e_acc, e_lst, e_red, e_ready, e_busy} = '0;
            e_ra = '0;
            e_aa = '0;
         end else begin
            cyc++;
            pre  = m_credits;
            acc  = ifc.inst_valid && e_ready;
            fire = (mq.size() > 0) && !(mq[0].lst && m_credits == 0);
            e_valid = fire;
            if (fire) begin
               b = mq.pop_front();
               e_ra = b.ra; e_aa = b.aa; e_acc = b.acc; e_lst = b.lst; e_red = b.red;
               if (b.lst) m_credits--;
            end
            if (i_credit) begin
               if (pre == CRED) m_err = 1'b1;
               else             m_credits++;
            end
            if (acc) begin
               for (int i = 0; i <= int'(ifc.inst_len); i++) begin
                  b.ra  = ifc.inst_rfaddr + 9'(i);
                  b.aa  = ifc.inst_aaddr + 9'(i);
                  b.acc = ifc.inst_accum;
                  b.lst = ifc.inst_last;
                  b.red = ifc.inst_reduce;
                  mq.push_back(b);
               end
            end
            e_ready = (mq.size() == 0) || (mq.size() == 1 && !(mq[0].lst && m_credits == 0));
            e_busy  = (mq.size() > 0);
         end
      end
   end

   // Every-cycle comparison against the model
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            chk("valid",      32'(o_valid),             32'(e_valid));
            chk("ready",      32'(ifc.inst_ready),      32'(e_ready));
            chk("busy",       32'(o_busy),              32'(e_busy));
            chk("credit_err", 32'(o_credit_err),        32'(m_err));
            chk("rf_raddr",   32'(o_rf_raddr),          32'(e_ra));
            chk("accum_addr", 32'(o_accum_addr),        32'(e_aa));
            chk("flags",      32'({o_accum, o_last, o_reduce}), 32'({e_acc, e_lst, e_red}));
         end
      end
   end

   // Record issued beats for the directed literal checks
   typedef struct {
      int         c;
      logic [8:0] ra;
      logic [8:0] aa;
   } cap_t;
   cap_t cap[$];

   initial begin
      cap_t e;
      forever begin
         @(posedge clk);
         #1;
         if (rst && o_valid) begin
            e.c = cyc; e.ra = o_rf_raddr; e.aa = o_accum_addr;
            cap.push_back(e);
         end
      end
   end

   task automatic send(input logic [8:0] rf, input logic [7:0] len, input logic [8:0] aa,
                       input logic a, input logic l, input logic r);
      logic rd;
      bit   ok;
      ok = 1'b0;
      ifc.inst_valid  = 1'b1;
      ifc.inst_rfaddr = rf;
      ifc.inst_len    = len;
      ifc.inst_aaddr  = aa;
      ifc.inst_accum  = a;
      ifc.inst_last   = l;
      ifc.inst_reduce = r;
      for (int k = 0; k < 300; k++) begin
         rd = ifc.inst_ready;
         @(posedge clk);
         @(negedge clk);
         if (rd) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) timeout("send_accept");
   endtask

   task automatic idle_inst();
      ifc.inst_valid = 1'b0;
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < 600; k++) begin
         @(negedge clk);
         if (!o_busy) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) timeout("wait_idle");
      @(negedge clk);
   endtask

   task automatic pulse_credit();
      i_credit = 1'b1;
      @(negedge clk);
      i_credit = 1'b0;
   endtask

   initial begin
      int acc_cyc;
      bit ok;
      rst = 1'b0;
      i_credit = 1'b0;
      ifc.inst_valid = 1'b0;
      ifc.inst_rfaddr = '0;
      ifc.inst_len = '0;
      ifc.inst_aaddr = '0;
      ifc.inst_accum = 1'b0;
      ifc.inst_last = 1'b0;
      ifc.inst_reduce = 1'b0;
      cycles(3);
      #1;
      chk("rst_valid", 32'(o_valid), 32'd0);
      chk("rst_ready", 32'(ifc.inst_ready), 32'd0);
      chk("rst_busy",  32'(o_busy), 32'd0);
      chk("rst_err",   32'(o_credit_err), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      cycles(2);

      // 1: single instruction, four back-to-back beats one cycle after accept
      cap.delete();
      send(9'd10, 8'd3, 9'd4, 1'b1, 1'b0, 1'b0);
      acc_cyc = cyc;
      idle_inst();
      wait_idle();
      chk("t1_count", 32'(cap.size()), 32'd4);
      if (cap.size() == 4) begin
         chk("t1_first_cycle", 32'(cap[0].c), 32'(acc_cyc + 1));
         for (int i = 0; i < 4; i++) begin
            chk("t1_raddr", 32'(cap[i].ra), 32'(10 + i));
            chk("t1_aaddr", 32'(cap[i].aa), 32'(4 + i));
            chk("t1_contig", 32'(cap[i].c), 32'(cap[0].c + i));
         end
      end

      // 2: two queued len=1 instructions, no bubble between them
      cap.delete();
      send(9'd20, 8'd1, 9'd30, 1'b0, 1'b0, 1'b1);
      send(9'd40, 8'd1, 9'd50, 1'b0, 1'b0, 1'b0);
      idle_inst();
      wait_idle();
      chk("t2_count", 32'(cap.size()), 32'd4);
      if (cap.size() == 4) begin
         chk("t2_r0", 32'(cap[0].ra), 32'd20);
         chk("t2_r1", 32'(cap[1].ra), 32'd21);
         chk("t2_r2", 32'(cap[2].ra), 32'd40);
         chk("t2_r3", 32'(cap[3].ra), 32'd41);
         chk("t2_contig", 32'(cap[3].c), 32'(cap[0].c + 3));
      end

      // 4: address wrap
      cap.delete();
      send(9'd511, 8'd2, 9'd510, 1'b0, 1'b0, 1'b0);
      idle_inst();
      wait_idle();
      chk("t4_count", 32'(cap.size()), 32'd3);
      if (cap.size() == 3) begin
         chk("t4_r0", 32'(cap[0].ra), 32'd511);
         chk("t4_r1", 32'(cap[1].ra), 32'd0);
         chk("t4_r2", 32'(cap[2].ra), 32'd1);
         chk("t4_a0", 32'(cap[0].aa), 32'd510);
         chk("t4_a1", 32'(cap[1].aa), 32'd511);
         chk("t4_a2", 32'(cap[2].aa), 32'd0);
      end

      // 3: drain to two credits, then a five-beat result instruction stalls
      send(9'd0, 8'd13, 9'd0, 1'b0, 1'b1, 1'b0);
      idle_inst();
      wait_idle();
      cap.delete();
      send(9'd100, 8'd4, 9'd200, 1'b0, 1'b1, 1'b0);
      idle_inst();
      cycles(6);
      chk("t3_stall2", 32'(cap.size()), 32'd2);
      chk("t3_busy", 32'(o_busy), 32'd1);
      pulse_credit();
      cycles(3);
      chk("t3_after1", 32'(cap.size()), 32'd3);
      pulse_credit();
      cycles(3);
      chk("t3_after2", 32'(cap.size()), 32'd4);
      cycles(3);
      chk("t3_wait5", 32'(cap.size()), 32'd4);
      pulse_credit();
      cycles(3);
      chk("t3_after3", 32'(cap.size()), 32'd5);
      wait_idle();
      repeat (16) pulse_credit();

      // 5: overflow return flags the sticky error; simultaneous consume+return holds count
      chk("t5_err_before", 32'(o_credit_err), 32'd0);
      pulse_credit();
      cycles(1);
      chk("t5_err_set", 32'(o_credit_err), 32'd1);
      send(9'd0, 8'd10, 9'd0, 1'b0, 1'b1, 1'b0);
      idle_inst();
      wait_idle();
      send(9'd300, 8'd0, 9'd300, 1'b0, 1'b1, 1'b0);
      i_credit = 1'b1;
      idle_inst();
      @(negedge clk);
      i_credit = 1'b0;
      wait_idle();
      cap.delete();
      send(9'd0, 8'd5, 9'd0, 1'b0, 1'b1, 1'b0);
      idle_inst();
      cycles(10);
      chk("t5_five_credits", 32'(cap.size()), 32'd5);
      pulse_credit();
      cycles(3);
      chk("t5_sixth", 32'(cap.size()), 32'd6);
      wait_idle();
      chk("t5_err_sticky", 32'(o_credit_err), 32'd1);

      // 6: reset in the middle of an instruction
      cap.delete();
      send(9'd200, 8'd7, 9'd0, 1'b0, 1'b0, 1'b0);
      idle_inst();
      ok = 1'b0;
      for (int k = 0; k < 50; k++) begin
         if (cap.size() >= 2) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) timeout("t6_beat2");
      #2 rst = 1'b0;
      #1;
      chk("t6_valid", 32'(o_valid), 32'd0);
      chk("t6_raddr", 32'(o_rf_raddr), 32'd0);
      chk("t6_busy",  32'(o_busy), 32'd0);
      chk("t6_ready", 32'(ifc.inst_ready), 32'd0);
      chk("t6_err",   32'(o_credit_err), 32'd0);
      cycles(2);
      rst = 1'b1;
      cap.delete();
      cycles(6);
      chk("t6_no_beats", 32'(cap.size()), 32'd0);
      send(9'd5, 8'd0, 9'd6, 1'b1, 1'b1, 1'b1);
      idle_inst();
      wait_idle();
      chk("t6_new_count", 32'(cap.size()), 32'd1);
      if (cap.size() == 1) chk("t6_new_raddr", 32'(cap[0].ra), 32'd5);

      cycles(2);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end
endmodule
